// File: rtl/ssd4_scan_capture.sv
// Rebuilds the {dp,nibble}x4 word from a scanned 4-digit seven-segment bus; 2 sync + STABLE_CYCLES to accept a digit.
// FRAME_VALID is registered one cycle after the last digit is accepted; pure monitor, never backpressures the driver.
module ssd4_scan_capture #(
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  SEG_IN,
    input  logic [3:0]  SEL_IN,
    output logic [19:0] DATA,
    output logic        FRAME_VALID,
    output logic [3:0]  DECODE_ERR,
    output logic        STALE
);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_N = SCW'(STABLE_CYCLES);
    localparam logic [TOW-1:0] TIMEOUT_N = TOW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {SEARCH, SETTLE, HOLD} state_t;

    logic [7:0]     seg_s1, seg_s2, seg_n;
    logic [3:0]     sel_s1, sel_s2, sel_n;
    logic           sel_vld;
    logic [11:0]    cur, lat, lat_nxt;
    logic [SCW-1:0] cnt, cnt_nxt;
    state_t         state, state_nxt;
    logic           accept;
    logic [4:0]     dec;
    logic [4:0]     shadow [4];
    logic [4:0]     sh_nxt [4];
    logic [3:0]     shadow_err, err_nxt, mask, mask_nxt;
    logic           frame_done;
    logic [TOW-1:0] to_cnt;

    // Returns {err, nibble}; unknown patterns (blank included) decode as 0 with err set.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D: return 5'h06;
            7'h07: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F: return 5'h09;
            7'h77: return 5'h0A;
            7'h7C: return 5'h0B;
            7'h39: return 5'h0C;
            7'h5E: return 5'h0D;
            7'h79: return 5'h0E;
            7'h71: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            seg_s1 <= SEG_IN;
            seg_s2 <= seg_s1;
            sel_s1 <= SEL_IN;
            sel_s2 <= sel_s1;
        end
    end

    assign seg_n   = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
    assign sel_n   = SEL_ACTIVE_LOW ? ~sel_s2 : sel_s2;
    assign sel_vld = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
    assign cur     = {sel_n, seg_n};

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            SEARCH: if (sel_vld) begin
                lat_nxt   = cur;
                cnt_nxt   = SCW'(1);
                state_nxt = SETTLE;
            end
            SETTLE: if (!sel_vld) begin
                state_nxt = SEARCH;
            end else if (cur == lat) begin
                cnt_nxt = cnt + SCW'(1);
            end else begin
                lat_nxt = cur;
                cnt_nxt = SCW'(1);
            end
            HOLD: if (!sel_vld) begin
                state_nxt = SEARCH;
            end else if (cur != lat) begin
                lat_nxt   = cur;
                cnt_nxt   = SCW'(1);
                state_nxt = SETTLE;
            end
            default: state_nxt = SEARCH;
        endcase
        // A digit is taken exactly once, on the cycle its run length hits the window.
        if (state_nxt == SETTLE && cnt_nxt == STABLE_N) begin
            accept    = 1'b1;
            state_nxt = HOLD;
        end
    end

    assign dec = decode7(lat_nxt[6:0]);

    always_comb begin
        for (int i = 0; i < 4; i++) sh_nxt[i] = shadow[i];
        err_nxt  = shadow_err;
        mask_nxt = mask;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_nxt[8+i]) begin
                    sh_nxt[i]  = {~lat_nxt[7], dec[3:0]};
                    err_nxt[i] = dec[4];
                end
            end
            mask_nxt = mask | lat_nxt[11:8];
        end
        frame_done = (mask_nxt == 4'hF);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= SEARCH;
            lat         <= '0;
            cnt         <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= 5'h10;
            shadow_err  <= '0;
            mask        <= '0;
            DATA        <= 20'h84210;
            DECODE_ERR  <= '0;
            FRAME_VALID <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            lat         <= lat_nxt;
            cnt         <= cnt_nxt;
            for (int i = 0; i < 4; i++) shadow[i] <= sh_nxt[i];
            shadow_err  <= err_nxt;
            mask        <= frame_done ? 4'h0 : mask_nxt;
            FRAME_VALID <= frame_done;
            if (frame_done) begin
                DATA       <= {sh_nxt[3], sh_nxt[2], sh_nxt[1], sh_nxt[0]};
                DECODE_ERR <= err_nxt;
            end
            if (FRAME_VALID)
                to_cnt <= '0;
            else if (to_cnt != TIMEOUT_N)
                to_cnt <= to_cnt + TOW'(1);
        end
    end

    assign STALE = (to_cnt == TIMEOUT_N);

endmodule

// File: tb/tb_ssd4_scan_capture.sv
// Drives scanned seven-segment traffic into ssd4_scan_capture and compares every cycle
// against a run-length reference model plus directed frame/stale expectations.
module tb_ssd4_scan_capture;
    localparam int STABLE = 8;
    localparam int TMO    = 200;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  SEG_IN;
    logic [3:0]  SEL_IN;
    logic [19:0] DATA;
    logic        FRAME_VALID;
    logic [3:0]  DECODE_ERR;
    logic        STALE;

    always #5 CLK = ~CLK;

    ssd4_scan_capture #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TMO),
        .SEG_ACTIVE_LOW(1'b1),
        .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SEG_IN     (SEG_IN),
        .SEL_IN     (SEL_IN),
        .DATA       (DATA),
        .FRAME_VALID(FRAME_VALID),
        .DECODE_ERR (DECODE_ERR),
        .STALE      (STALE)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [7:0] GHOST_RAW = 8'hB6;  // lit pattern 7'h49: not a hex glyph

    // Reference state: raw inputs in flight through the synchronizer, run length of the seen value.
    logic [11:0] p1, p2, last_seen;
    int          run;
    logic [4:0]  m_sh [4];
    logic [3:0]  m_err, m_mask, e_err;
    logic [19:0] e_data;
    logic        e_fv;
    int          idle;

    int cyc = 0, fv_count = 0, last_fv = 0, rise = 0, fall = 0;
    logic prev_stale = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        p1 = '0; p2 = '0; last_seen = '0; run = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 5'h10;
        m_err = '0; m_mask = '0; e_err = '0; e_data = 20'h84210; e_fv = 1'b0; idle = 0;
    endtask

    task automatic model_edge(input logic [11:0] raw);
        logic [11:0] seen;
        logic [3:0]  nib;
        logic        found;
        int          d;
        seen = ~p2;
        p2 = p1;
        p1 = raw;
        if (e_fv) idle = 0;
        else if (idle < TMO) idle++;
        e_fv = 1'b0;
        if ($countones(seen[11:8]) == 1)
            run = (run > 0 && seen == last_seen) ? run + 1 : 1;
        else
            run = 0;
        last_seen = seen;
        if (run == STABLE) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (seen[8+i]) d = i;
            found = 1'b0;
            nib = 4'h0;
            for (int k = 0; k < 16; k++)
                if (hex7[k] == seen[6:0]) begin found = 1'b1; nib = 4'(k); end
            m_sh[d]   = {~seen[7], nib};
            m_err[d]  = ~found;
            m_mask[d] = 1'b1;
            if (m_mask == 4'hF) begin
                e_data = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
                e_err  = m_err;
                e_fv   = 1'b1;
                m_mask = '0;
            end
        end
    endtask

    task automatic tick(input logic [7:0] seg, input logic [3:0] sel);
        SEG_IN = seg;
        SEL_IN = sel;
        @(posedge CLK);
        model_edge({sel, seg});
        #1;
        cyc++;
        chk("data", DATA, e_data);
        chk("frame_valid", FRAME_VALID, e_fv);
        chk("decode_err", DECODE_ERR, e_err);
        chk("stale", STALE, idle == TMO);
        if (FRAME_VALID) begin fv_count++; last_fv = cyc; end
        if (STALE && !prev_stale) rise = cyc;
        if (!STALE && prev_stale) fall = cyc;
        prev_stale = STALE;
    endtask

    // Word is in DATA format; digit 0 is scanned first, bad[d] blanks that digit.
    task automatic scan(input logic [19:0] word, input int per, input int glitch, input logic [3:0] bad);
        logic [4:0] ent;
        logic [6:0] pat;
        logic [7:0] seg_raw;
        logic [3:0] sel_raw;
        fv_count = 0;
        for (int d = 0; d < 4; d++) begin
            ent     = word[d*5 +: 5];
            pat     = bad[d] ? 7'h00 : hex7[ent[3:0]];
            seg_raw = ~{~ent[4], pat};
            sel_raw = ~(4'b0001 << d);
            for (int i = 0; i < per; i++)
                tick((i < glitch) ? GHOST_RAW : seg_raw, sel_raw);
        end
    endtask

    initial begin
        logic [19:0] w;
        logic [3:0]  nib;
        RST_N  = 1'b1;
        SEG_IN = 8'hFF;
        SEL_IN = 4'hF;
        #1 RST_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_data", DATA, 20'h84210);
        chk("reset_fv", FRAME_VALID, 1'b0);
        chk("reset_err", DECODE_ERR, 4'h0);
        chk("reset_stale", STALE, 1'b0);
        RST_N = 1'b1;

        for (int r = 0; r < 2; r++) begin
            scan(20'h8C874, 50, 0, 4'h0);
            chk("clean_fv_count", fv_count, 1);
            chk("clean_data", DATA, 20'h8C874);
            chk("clean_err", DECODE_ERR, 4'h0);
        end

        for (int r = 0; r < 2; r++) begin
            scan(20'h8C874, 50, 3, 4'h0);
            chk("ghost_fv_count", fv_count, 1);
            chk("ghost_data", DATA, 20'h8C874);
        end

        scan(20'h8C874, 50, 0, 4'b0100);
        chk("bad_data", DATA, 20'h8C074);
        chk("bad_err", DECODE_ERR, 4'b0100);
        scan(20'h8C874, 50, 0, 4'h0);
        chk("bad_clear_err", DECODE_ERR, 4'h0);
        chk("bad_clear_data", DATA, 20'h8C874);

        fv_count = 0;
        for (int i = 0; i < 100; i++) tick(~{1'b0, hex7[5]}, ~4'b0011);
        chk("dual_sel_fv_count", fv_count, 0);
        scan(20'h8C874, 50, 0, 4'h0);
        chk("dual_sel_resume_fv", fv_count, 1);
        chk("dual_sel_resume_data", DATA, 20'h8C874);

        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 4; d++) begin
                nib = 4'($urandom_range(0, 15));
                w[d*5 +: 5] = {1'($urandom_range(0, 1)), nib};
            end
            scan(w, $urandom_range(20, 60), $urandom_range(0, 5), 4'h0);
            chk("rand_fv_count", fv_count, 1);
            chk("rand_data", DATA, w);
        end

        scan(20'h8C874, 50, 0, 4'h0);
        for (int i = 0; i < 250; i++) tick(8'hFF, 4'hF);
        chk("stale_rise_delay", rise - last_fv, 201);
        chk("stale_held_data", DATA, 20'h8C874);
        scan(20'h84210 ^ 20'h00421, 50, 0, 4'h0);
        chk("stale_clear_delay", fall - last_fv, 1);

        // Async reset part-way through a digit's settle window.
        for (int i = 0; i < 5; i++) tick(~{1'b1, hex7[9]}, 4'b1110);
        RST_N = 1'b0;
        #1;
        chk("midreset_data", DATA, 20'h84210);
        chk("midreset_fv", FRAME_VALID, 1'b0);
        chk("midreset_err", DECODE_ERR, 4'h0);
        chk("midreset_stale", STALE, 1'b0);
        model_reset();
        #2 RST_N = 1'b1;
        scan(20'h8C874, 50, 0, 4'h0);
        chk("post_reset_fv", fv_count, 1);
        chk("post_reset_data", DATA, 20'h8C874);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
